// File: rtl/sprite_line_engine.sv
// Sprite scanline engine: fetches the next line's sprite row into a line buffer during
// horizontal blank, then serves scaled pixels combinationally during active video.
module sprite_line_engine #(
   parameter int CIDXW       = 3,
   parameter int SPR_W_LOG2  = 5,
   parameter int SPR_H_LOG2  = 5,
   parameter int SCALE_LOG2  = 1,
   parameter int H_VIS_START = 144,
   parameter int H_VIS_END   = 784,
   parameter int V_TOTAL     = 525
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [9:0]                       hCount,
   input  logic [9:0]                       vCount,
   input  logic                             spr_en,
   input  logic [9:0]                       spr_x,
   input  logic [9:0]                       spr_y,
   output logic [SPR_W_LOG2+SPR_H_LOG2-1:0] rom_addr,
   input  logic [CIDXW-1:0]                 rom_data,
   output logic                             spr_drawing,
   output logic [CIDXW-1:0]                 spr_indx,
   output logic                             busy
);
   localparam int SPR_W = 1 << SPR_W_LOG2;
   localparam int SPR_H = 1 << SPR_H_LOG2;

   typedef enum logic [1:0] {IDLE, ADDR, LAST} state_t;

   state_t                            state_q, state_d;
   logic [9:0]                        prev_h_q;
   logic [9:0]                        x_q, x_d;
   logic [SPR_H_LOG2-1:0]             row_q, row_d;
   logic [SPR_W_LOG2-1:0]             col_q, col_d;
   logic [SPR_W_LOG2+SPR_H_LOG2-1:0]  rom_addr_q, rom_addr_d;
   logic                              line_valid_q, line_valid_d;
   logic [CIDXW-1:0]                  buf_q [SPR_W];
   logic [CIDXW-1:0]                  buf_d [SPR_W];

   logic                              trig;
   logic [9:0]                        next_v;
   logic [10:0]                       rel, rel_s;
   logic                              in_range;
   logic [10:0]                       dx, dx_s;
   logic                              hit;
   logic [CIDXW-1:0]                  px;

   // One trigger per line: only the first clock that hCount sits on H_VIS_END.
   assign trig     = (hCount == 10'(H_VIS_END)) && (prev_h_q != 10'(H_VIS_END));
   assign next_v   = (vCount == 10'(V_TOTAL - 1)) ? 10'd0 : vCount + 10'd1;
   assign rel      = {1'b0, next_v} - {1'b0, spr_y};
   assign rel_s    = rel >> SCALE_LOG2;
   assign in_range = spr_en && (next_v >= spr_y) && (rel_s < 11'(SPR_H));

   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      row_d        = row_q;
      col_d        = col_q;
      rom_addr_d   = rom_addr_q;
      line_valid_d = line_valid_q;
      buf_d        = buf_q;
      case (state_q)
         IDLE: begin
            if (trig) begin
               x_d          = spr_x;
               line_valid_d = 1'b0;
               if (in_range) begin
                  state_d    = ADDR;
                  col_d      = '0;
                  row_d      = rel_s[SPR_H_LOG2-1:0];
                  rom_addr_d = {rel_s[SPR_H_LOG2-1:0], {SPR_W_LOG2{1'b0}}};
               end
            end
         end
         ADDR: begin
            // rom_data lags rom_addr by one clock, so it belongs to the previous column.
            if (col_q != '0) buf_d[col_q - 1'b1] = rom_data;
            if (col_q == '1) begin
               state_d = LAST;
            end else begin
               col_d      = col_q + 1'b1;
               rom_addr_d = {row_q, col_q + 1'b1};
            end
         end
         LAST: begin
            buf_d[col_q] = rom_data;
            line_valid_d = 1'b1;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         prev_h_q     <= '0;
         x_q          <= '0;
         row_q        <= '0;
         col_q        <= '0;
         rom_addr_q   <= '0;
         line_valid_q <= 1'b0;
         for (int i = 0; i < SPR_W; i++) buf_q[i] <= '0;
      end else begin
         state_q      <= state_d;
         prev_h_q     <= hCount;
         x_q          <= x_d;
         row_q        <= row_d;
         col_q        <= col_d;
         rom_addr_q   <= rom_addr_d;
         line_valid_q <= line_valid_d;
         buf_q        <= buf_d;
      end
   end

   // Draw path: hCount < x_q rejects left-of-sprite pixels so dx never wraps.
   assign dx   = {1'b0, hCount} - {1'b0, x_q};
   assign dx_s = dx >> SCALE_LOG2;
   assign hit  = line_valid_q && (hCount >= 10'(H_VIS_START)) && (hCount < 10'(H_VIS_END)) &&
                 (hCount >= x_q) && (dx_s < 11'(SPR_W));
   assign px   = buf_q[dx_s[SPR_W_LOG2-1:0]];

   assign spr_drawing = hit && (px != '0);
   assign spr_indx    = spr_drawing ? px : '0;
   assign rom_addr    = rom_addr_q;
   assign busy        = (state_q != IDLE);
endmodule

// File: tb/tb_sprite_line_engine.sv
// Directed bench for sprite_line_engine: table of fetch/pixel vectors plus hand sequences.
module tb_sprite_line_engine;
   logic       clk = 1'b0;
   logic       reset;
   logic [9:0] hCount, vCount, spr_x, spr_y;
   logic       spr_en;
   logic [9:0] rom_addr;
   logic [2:0] rom_data;
   logic       spr_drawing;
   logic [2:0] spr_indx;
   logic       busy;

   int total = 0;
   int bad   = 0;

   sprite_line_engine dut (
      .clk(clk), .reset(reset), .hCount(hCount), .vCount(vCount),
      .spr_en(spr_en), .spr_x(spr_x), .spr_y(spr_y),
      .rom_addr(rom_addr), .rom_data(rom_data),
      .spr_drawing(spr_drawing), .spr_indx(spr_indx), .busy(busy)
   );

   always #5 clk = ~clk;

   // Sprite ROM: pixel = (col ^ row) mod 8, one clock read latency.
   always @(posedge clk) rom_data <= rom_addr[2:0] ^ rom_addr[7:5];

   typedef struct {
      logic       en;
      logic [9:0] x;
      logic [9:0] y;
      logic [9:0] fv;
      int         busy_n;
      logic [4:0] row;
      logic [9:0] h;
      logic       d;
      logic [2:0] idx;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic en, input int x, input int y, input int fv, input int bn,
                      input int row, input int h, input logic d, input int idx);
      vec_t v;
      v.en = en; v.x = 10'(x); v.y = 10'(y); v.fv = 10'(fv); v.busy_n = bn;
      v.row = 5'(row); v.h = 10'(h); v.d = d; v.idx = 3'(idx);
      tbl.push_back(v);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic pix(input string name, input int h, input logic d, input int idx);
      hCount = 10'(h);
      #1;
      chk({name, " drawing"}, int'(spr_drawing), int'(d));
      chk({name, " indx"}, int'(spr_indx), idx);
      hCount = 10'd0;
      tick();
   endtask

   task automatic fetch(input logic en, input int x, input int y, input int v,
                        output int n, output logic [9:0] first_addr);
      spr_en = en; spr_x = 10'(x); spr_y = 10'(y); vCount = 10'(v);
      hCount = 10'd783;
      tick();
      hCount = 10'd784;
      tick();
      first_addr = rom_addr;
      n = 0;
      while (busy && n < 50) begin
         n++;
         hCount = hCount + 10'd1;
         tick();
      end
      hCount = 10'd0;
      vCount = (v == 524) ? 10'd0 : 10'(v + 1);
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [9:0] fa;

      // en, x, y, fetch line, busy clks, row, hCount, drawing, indx
      add(1, 200, 100,  99, 33,  0, 199, 0, 0);
      add(1, 200, 100,  99, 33,  0, 200, 0, 0);
      add(1, 200, 100,  99, 33,  0, 201, 0, 0);
      add(1, 200, 100,  99, 33,  0, 202, 1, 1);
      add(1, 200, 100,  99, 33,  0, 203, 1, 1);
      add(1, 200, 100,  99, 33,  0, 216, 0, 0);
      add(1, 200, 100,  99, 33,  0, 218, 1, 1);
      add(1, 200, 100,  99, 33,  0, 262, 1, 7);
      add(1, 200, 100,  99, 33,  0, 263, 1, 7);
      add(1, 200, 100,  99, 33,  0, 264, 0, 0);
      add(1, 200, 100, 162, 33, 31, 200, 1, 7);
      add(1, 200, 100, 162, 33, 31, 260, 1, 1);
      add(1, 200, 100, 162, 33, 31, 262, 0, 0);
      add(1, 200, 100, 163,  0,  0, 202, 0, 0);
      add(1, 200, 101,  99,  0,  0, 202, 0, 0);
      add(1, 200, 100, 100, 33,  0, 202, 1, 1);
      add(1, 200, 100, 101, 33,  1, 200, 1, 1);
      add(1, 200, 100, 101, 33,  1, 202, 0, 0);
      add(1, 200, 100, 101, 33,  1, 204, 1, 3);
      add(1, 770, 100,  99, 33,  0, 770, 0, 0);
      add(1, 770, 100,  99, 33,  0, 772, 1, 1);
      add(1, 770, 100,  99, 33,  0, 783, 1, 6);
      add(1, 770, 100,  99, 33,  0, 784, 0, 0);
      add(1, 770, 100,  99, 33,  0, 785, 0, 0);
      add(1, 770, 100,  99, 33,  0,   0, 0, 0);
      add(1, 770, 100,  99, 33,  0, 143, 0, 0);
      add(1, 200,   0, 524, 33,  0, 202, 1, 1);
      add(1, 200,   0, 523,  0,  0, 202, 0, 0);
      add(0, 200, 100,  99,  0,  0, 202, 0, 0);
      add(1, 100, 100,  99, 33,  0, 143, 0, 0);
      add(1, 100, 100,  99, 33,  0, 144, 1, 6);
      add(1, 100, 100,  99, 33,  0, 146, 1, 7);

      reset = 1'b1; hCount = '0; vCount = '0; spr_en = 1'b0; spr_x = '0; spr_y = '0;
      tick();
      tick();
      chk("reset busy", int'(busy), 0);
      chk("reset rom_addr", int'(rom_addr), 0);
      hCount = 10'd202;
      #1;
      chk("reset drawing", int'(spr_drawing), 0);
      chk("reset indx", int'(spr_indx), 0);
      hCount = '0;
      reset = 1'b0;
      tick();
      pix("pre-fetch", 202, 0, 0);

      foreach (tbl[i]) begin
         fetch(tbl[i].en, int'(tbl[i].x), int'(tbl[i].y), int'(tbl[i].fv), n, fa);
         chk($sformatf("vec%0d busy clks", i), n, tbl[i].busy_n);
         if (tbl[i].busy_n != 0)
            chk($sformatf("vec%0d first rom_addr", i), int'(fa), int'({tbl[i].row, 5'd0}));
         pix($sformatf("vec%0d h=%0d", i, tbl[i].h), int'(tbl[i].h), tbl[i].d, int'(tbl[i].idx));
      end

      // Reset in the middle of a fetch, around col 10.
      fetch(1, 200, 100, 99, n, fa);
      spr_en = 1'b1; spr_x = 10'd200; spr_y = 10'd100; vCount = 10'd99;
      hCount = 10'd783;
      tick();
      hCount = 10'd784;
      tick();
      repeat (10) begin hCount = hCount + 10'd1; tick(); end
      chk("midfetch busy before reset", int'(busy), 1);
      reset = 1'b1;
      #1;
      chk("midfetch busy in reset", int'(busy), 0);
      hCount = 10'd202;
      #1;
      chk("midfetch drawing in reset", int'(spr_drawing), 0);
      hCount = 10'd0;
      tick();
      reset = 1'b0;
      tick();
      chk("after reset busy", int'(busy), 0);
      pix("after reset h=202", 202, 0, 0);
      pix("after reset h=262", 262, 0, 0);
      fetch(1, 200, 100, 99, n, fa);
      chk("refetch busy clks", n, 33);
      pix("refetch h=202", 202, 1, 1);

      // hCount parked on H_VIS_END: exactly one fetch.
      spr_en = 1'b1; spr_x = 10'd200; spr_y = 10'd100; vCount = 10'd99;
      hCount = 10'd783;
      tick();
      hCount = 10'd784;
      n = 0;
      repeat (45) begin tick(); if (busy) n++; end
      chk("held trigger busy clks", n, 33);
      hCount = 10'd0;
      tick();

      // spr_x moves mid-line: current line unaffected.
      fetch(1, 200, 100, 99, n, fa);
      spr_x = 10'd300;
      hCount = 10'd250;
      tick();
      tick();
      hCount = 10'd0;
      tick();
      pix("xmove old pos", 202, 1, 1);
      pix("xmove new pos", 302, 0, 0);
      fetch(1, 300, 100, 99, n, fa);
      pix("xmove next line new", 302, 1, 1);
      pix("xmove next line old", 202, 0, 0);

      // spr_en low at trigger, raised mid-line.
      fetch(0, 200, 100, 99, n, fa);
      chk("en low busy clks", n, 0);
      spr_en = 1'b1;
      tick();
      pix("en rise mid-line", 202, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
